text_line_sequencer: RTL and testbench
======================================

# text_line_sequencer

Sequences the 8x12 character blender across one scanline of a text-mode display. For each character cell in the requested text row, it fetches the character code and colours from text RAM over a request/acknowledge handshake. It then steps the blender through the 8 pixel columns of that cell and writes each blended 12-bit pixel into the scanline buffer. It sits between the video timing generator, which issues one start per scanline, and the blender/line-buffer datapath.

## Interface
- COLS, 80: character cells per text row (1..128)
- RAM_AW, 13: text RAM word-address width
- LB_AW, 10: line buffer address width; must satisfy 2^LB_AW >= COLS*8
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse; accepted only in IDLE
- i_abort  in  1  abandon the current line; return to IDLE
- i_text_row  in  6  text row index, sampled on accepted start
- i_cell_row  in  4  pixel row within the cell (0..11 valid), sampled on accepted start
- o_ram_req  out  1  text RAM read request
- o_ram_addr  out  RAM_AW  word address = text_row*COLS + cell, truncated to RAM_AW
- i_ram_ack  in  1  read data valid; completes the request
- i_ram_data  in  32  {char[31:24], fg[23:12], bg[11:0]}
- o_char  out  8  to blender
- o_row  out  4  to blender
- o_column  out  3  to blender
- o_fg_color  out  12  to blender
- o_bg_color  out  12  to blender
- i_blend_color  in  12  blender result (combinational from o_*)
- o_lb_we  out  1  line buffer write enable
- o_lb_addr  out  LB_AW  pixel address = cell*8 + column
- o_lb_data  out  12  pixel colour
- o_busy  out  1  high whenever the state is not IDLE
- o_done  out  1  one-cycle pulse when the line is complete

## Operation
- States: IDLE, FETCH, PIXELS, DONE.
- IDLE, on i_start:
  - latch the row inputs and set cell=0
  - go to FETCH
- FETCH:
  - o_ram_req=1 and o_ram_addr are held stable until i_ram_ack.
  - On ack, latch char/fg/bg into o_char/o_fg_color/o_bg_color, set column=0, drop req, go to PIXELS.
- PIXELS:
  - One column per cycle, column 0..7.
  - After column 7: go to FETCH (cell+1) if cell < COLS-1, else go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Write path:
  - o_lb_we, o_lb_addr and o_lb_data are registered from the PIXELS cycle presenting that column.
  - o_lb_data is i_blend_color, or o_bg_color unblended when the latched i_cell_row >= 12.
- i_abort in any state:
  - next state is IDLE, req and we are cleared, no o_done.
  - i_abort wins over a simultaneous i_ram_ack or i_start.
- i_start while not IDLE is ignored.
- Reset values: all outputs 0, state IDLE, cell=0, column=0.
- Reset mid-line leaves the line buffer partially written; this is acceptable.

## Timing
- Accepted start at cycle S: o_ram_req=1 at S+1 with address text_row*COLS.
- Ack at cycle A: blender inputs valid at A+1 with column 0; o_lb_we=1 for column 0 at A+2.
- Each cell costs 8 PIXELS cycles plus FETCH cycles (at least 1 if ack arrives in the first request cycle).
- Zero-wait RAM: each line takes COLS*9 + 2 cycles from start to o_done.
- Final write of pixel COLS*8-1 occurs in the same cycle the state is DONE; o_done is the cycle after that write.
- o_lb_we is high for exactly 8 consecutive cycles per cell, with no gaps within a cell.
- Exactly COLS*8 writes per completed line.
- i_ram_data is sampled only in the ack cycle.
- o_ram_addr changes only while o_ram_req=0.

## Test plan
- COLS=2, text_row=3, cell_row=5, zero-wait RAM returning {0x41, 0xFFF, 0x000}:
  - addresses 6 then 7
  - 16 writes to addresses 0..15
  - o_row=5
  - o_done exactly 20 cycles after start
- RAM ack delayed 4 cycles for cell 1: req and address held stable, no writes during the wait, write ordering unchanged.
- cell_row=13 with bg=0x123: all 16 written pixels are 0x123 regardless of i_blend_color.
- i_abort during PIXELS of cell 0 at column 4:
  - no further writes
  - o_done never asserts
  - o_busy=0 next cycle
  - a new start then works normally
- i_start pulsed mid-line is ignored (write count unchanged); i_abort coincident with ack: ack data is not latched and the block returns to IDLE.
- i_rst_n asserted asynchronously mid-FETCH: all outputs 0 immediately; the block restarts cleanly after release.

Source files
------------

// File: rtl/text_line_sequencer.sv
// text_line_sequencer
//   Walks one scanline of a text-mode display. For each character cell of the
//   requested text row it reads {char, fg, bg} from text RAM, then presents the
//   8 pixel columns of that cell to the blender and writes each blended pixel
//   into the scanline buffer.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start, i_abort        line start pulse (IDLE only), abandon current line
//   i_text_row, i_cell_row  text row and pixel row within the cell
//   o_ram_req/o_ram_addr    text RAM read request and word address
//   i_ram_ack/i_ram_data    read completion and {char, fg, bg} data
//   o_char..o_bg_color      blender inputs; i_blend_color is its result
//   o_lb_we/addr/data       line buffer write port
//   o_busy, o_done          not-idle flag, end-of-line pulse
//
// Text RAM handshake: o_ram_req rises with a valid o_ram_addr and both stay
// stable until the cycle in which i_ram_ack is high; that cycle completes the
// transfer and is the only cycle in which i_ram_data is sampled. The address
// only moves while o_ram_req is low.
module text_line_sequencer #(
  parameter int COLS   = 80,
  parameter int RAM_AW = 13,
  parameter int LB_AW  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [5:0]        i_text_row,
  input  logic [3:0]        i_cell_row,
  output logic              o_ram_req,
  output logic [RAM_AW-1:0] o_ram_addr,
  input  logic              i_ram_ack,
  input  logic [31:0]       i_ram_data,
  output logic [7:0]        o_char,
  output logic [3:0]        o_row,
  output logic [2:0]        o_column,
  output logic [11:0]       o_fg_color,
  output logic [11:0]       o_bg_color,
  input  logic [11:0]       i_blend_color,
  output logic              o_lb_we,
  output logic [LB_AW-1:0]  o_lb_addr,
  output logic [11:0]       o_lb_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST_CELL = CW'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_PIXELS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cell_q, cell_d;
  logic [2:0]        column_q, column_d;
  logic [3:0]        row_q, row_d;
  logic [7:0]        char_q, char_d;
  logic [11:0]       fg_q, fg_d;
  logic [11:0]       bg_q, bg_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              lb_we_q, lb_we_d;
  logic [LB_AW-1:0]  lb_addr_q, lb_addr_d;
  logic [11:0]       lb_data_q, lb_data_d;
  logic              done_q, done_d;

  // Pixel index within the line is simply {cell, column} since cells are 8 wide.
  logic [CW+2:0]     pix_idx;
  assign pix_idx = {cell_q, column_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cell_q     <= '0;
      column_q   <= '0;
      row_q      <= '0;
      char_q     <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      ram_addr_q <= '0;
      lb_we_q    <= 1'b0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cell_q     <= cell_d;
      column_q   <= column_d;
      row_q      <= row_d;
      char_q     <= char_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      ram_addr_q <= ram_addr_d;
      lb_we_q    <= lb_we_d;
      lb_addr_q  <= lb_addr_d;
      lb_data_q  <= lb_data_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cell_d     = cell_q;
    column_d   = column_q;
    row_d      = row_q;
    char_d     = char_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    ram_addr_d = ram_addr_q;
    lb_we_d    = 1'b0;
    lb_addr_d  = lb_addr_q;
    lb_data_d  = lb_data_q;
    done_d     = 1'b0;

    // Abort overrides everything, including a same-cycle ack or start, so
    // nothing is latched and no write or done pulse is issued.
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            row_d      = i_cell_row;
            cell_d     = '0;
            ram_addr_d = RAM_AW'(int'(i_text_row) * COLS);
            state_d    = S_FETCH;
          end
        end
        S_FETCH: begin
          if (i_ram_ack) begin
            char_d   = i_ram_data[31:24];
            fg_d     = i_ram_data[23:12];
            bg_d     = i_ram_data[11:0];
            column_d = 3'd0;
            state_d  = S_PIXELS;
          end
        end
        S_PIXELS: begin
          lb_we_d   = 1'b1;
          lb_addr_d = LB_AW'(pix_idx);
          // Rows 12..15 lie outside the glyph: show plain background.
          lb_data_d = (row_q >= 4'd12) ? bg_q : i_blend_color;
          column_d  = column_q + 3'd1;
          if (column_q == 3'd7) begin
            if (cell_q == LAST_CELL) begin
              state_d = S_DONE;
            end else begin
              cell_d     = cell_q + CW'(1);
              ram_addr_d = ram_addr_q + RAM_AW'(1);
              state_d    = S_FETCH;
            end
          end
        end
        S_DONE: begin
          // o_done is registered so it lands the cycle after the last write.
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_ram_req  = (state_q == S_FETCH);
  assign o_ram_addr = ram_addr_q;
  assign o_char     = char_q;
  assign o_row      = row_q;
  assign o_column   = column_q;
  assign o_fg_color = fg_q;
  assign o_bg_color = bg_q;
  assign o_lb_we    = lb_we_q;
  assign o_lb_addr  = lb_addr_q;
  assign o_lb_data  = lb_data_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = done_q;

endmodule

// File: tb/tb_text_line_sequencer.sv
// Bench for text_line_sequencer with a 2-cell line. A text RAM responder with
// per-address wait states, a simple glyph blender and a write scoreboard run
// alongside directed line vectors and hand-written abort/reset sequences.
module tb_text_line_sequencer;

  localparam int COLS   = 2;
  localparam int RAM_AW = 13;
  localparam int LB_AW  = 4;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_start;
  logic              i_abort;
  logic [5:0]        i_text_row;
  logic [3:0]        i_cell_row;
  logic              o_ram_req;
  logic [RAM_AW-1:0] o_ram_addr;
  logic              i_ram_ack;
  logic [31:0]       i_ram_data;
  logic [7:0]        o_char;
  logic [3:0]        o_row;
  logic [2:0]        o_column;
  logic [11:0]       o_fg_color;
  logic [11:0]       o_bg_color;
  logic [11:0]       i_blend_color;
  logic              o_lb_we;
  logic [LB_AW-1:0]  o_lb_addr;
  logic [11:0]       o_lb_data;
  logic              o_busy;
  logic              o_done;

  text_line_sequencer #(.COLS(COLS), .RAM_AW(RAM_AW), .LB_AW(LB_AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_text_row(i_text_row), .i_cell_row(i_cell_row),
    .o_ram_req(o_ram_req), .o_ram_addr(o_ram_addr),
    .i_ram_ack(i_ram_ack), .i_ram_data(i_ram_data),
    .o_char(o_char), .o_row(o_row), .o_column(o_column),
    .o_fg_color(o_fg_color), .o_bg_color(o_bg_color),
    .i_blend_color(i_blend_color),
    .o_lb_we(o_lb_we), .o_lb_addr(o_lb_addr), .o_lb_data(o_lb_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- text RAM contents ----------------
  function automatic logic [31:0] ram_word(input logic [12:0] a);
    case (a)
      13'd6, 13'd7:   return {8'h41, 12'hFFF, 12'h000};
      13'd20, 13'd21: return {8'hA5, 12'h456, 12'h123};
      default:        return {a[7:0] ^ 8'h5A, a[3:0], 8'h3C, 4'h9, a[7:0]};
    endcase
  endfunction

  // Expected pixel: glyph bit = char[col] xor row[0]; rows >= 12 are background.
  function automatic logic [11:0] exp_pix(input logic [31:0] w, input logic [3:0] cr, input int col);
    logic [7:0] ch;
    ch = w[31:24];
    if (cr >= 4'd12) return w[11:0];
    return (ch[col] ^ cr[0]) ? w[23:12] : w[11:0];
  endfunction

  // ---------------- blender ----------------
  // Out-of-glyph rows give a poison colour so unblended output is observable.
  always @* begin
    if (o_row >= 4'd12) i_blend_color = 12'hBAD;
    else i_blend_color = (o_char[o_column] ^ o_row[0]) ? o_fg_color : o_bg_color;
  end

  // ---------------- RAM responder + monitors ----------------
  logic        auto_ram = 1'b1;
  logic        ack_auto = 1'b0;
  logic [31:0] data_auto = 32'hDEADBEEF;
  logic        ack_man = 1'b0;
  logic [31:0] data_man = 32'hDEADBEEF;
  assign i_ram_ack  = auto_ram ? ack_auto : ack_man;
  assign i_ram_data = auto_ram ? data_auto : data_man;

  int delay_addr = -1;
  int delay_n = 0;
  int wait_cnt = 0;
  logic [RAM_AW-1:0] got_addr_q[$];
  logic [LB_AW+11:0] exp_q[$];
  int n_writes = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic prev_req = 1'b0;
  logic [RAM_AW-1:0] prev_addr = '0;

  always @(negedge i_clk) begin
    // write scoreboard
    if (o_lb_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {o_lb_addr, o_lb_data}, '0);
      end else begin
        chk("lb_write", {o_lb_addr, o_lb_data}, exp_q.pop_front());
      end
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    // request must hold its address, and no writes occur while waiting
    if (o_ram_req && prev_req) begin
      chk("req_addr_stable", o_ram_addr, prev_addr);
      chk("no_write_in_wait", o_lb_we, 1'b0);
    end
    prev_req  = o_ram_req;
    prev_addr = o_ram_addr;
    // responder: ack after the configured number of wait cycles
    if (o_ram_req) begin
      if (wait_cnt >= ((int'(o_ram_addr) == delay_addr) ? delay_n : 0)) begin
        ack_auto  = 1'b1;
        data_auto = ram_word(o_ram_addr);
        got_addr_q.push_back(o_ram_addr);
        wait_cnt  = 0;
      end else begin
        ack_auto  = 1'b0;
        data_auto = 32'hDEADBEEF;
        wait_cnt++;
      end
    end else begin
      ack_auto  = 1'b0;
      data_auto = 32'hDEADBEEF;
      wait_cnt  = 0;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]  text_row;
    logic [3:0]  cell_row;
    int          delay_addr;
    int          delay_n;
    logic        mid_start;
    logic [12:0] exp_addr0;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    logic [31:0] w;
    int s;
    bit seen;
    for (int c = 0; c < COLS; c++) begin
      w = ram_word(v.exp_addr0 + 13'(c));
      for (int col = 0; col < 8; col++)
        exp_q.push_back({4'(c * 8 + col), exp_pix(w, v.cell_row, col)});
    end
    got_addr_q.delete();
    done_cnt   = 0;
    n_writes   = 0;
    delay_addr = v.delay_addr;
    delay_n    = v.delay_n;
    @(negedge i_clk);
    i_text_row = v.text_row;
    i_cell_row = v.cell_row;
    i_start    = 1'b1;
    s = cyc;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("first_req", o_ram_req, 1'b1);
    chk("first_addr", o_ram_addr, v.exp_addr0);
    chk("row_out", o_row, v.cell_row);
    chk("busy_in_line", o_busy, 1'b1);
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge i_clk);
      #1;
      i_start = v.mid_start && (cyc == s + 8);
      if (i_start) i_text_row = 6'd7;
      if (done_cnt > 0) seen = 1;
    end
    i_start = 1'b0;
    chk("done_seen", seen, 1'b1);
    if (seen) chk("done_latency", done_cyc - s, v.exp_lat);
    repeat (3) @(negedge i_clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("idle_after_done", o_busy, 1'b0);
    chk("write_count", n_writes, COLS * 8);
    chk("writes_pending", exp_q.size(), 0);
    chk("fetch_count", got_addr_q.size(), COLS);
    if (got_addr_q.size() == COLS) begin
      chk("fetch_addr0", got_addr_q[0], v.exp_addr0);
      chk("fetch_addr1", got_addr_q[1], v.exp_addr0 + 13'd1);
    end
    exp_q.delete();
    delay_addr = -1;
    delay_n    = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, o_ram_req, 1'b0);
    chk({tag, "_addr"}, o_ram_addr, '0);
    chk({tag, "_char"}, o_char, '0);
    chk({tag, "_row"}, o_row, '0);
    chk({tag, "_column"}, o_column, '0);
    chk({tag, "_fg"}, o_fg_color, '0);
    chk({tag, "_bg"}, o_bg_color, '0);
    chk({tag, "_we"}, o_lb_we, 1'b0);
    chk({tag, "_lb_addr"}, o_lb_addr, '0);
    chk({tag, "_lb_data"}, o_lb_data, '0);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w;
    vecs[0] = '{6'd3,  4'd5,  -1, 0, 1'b0, 13'd6,   20};
    vecs[1] = '{6'd3,  4'd5,   7, 4, 1'b0, 13'd6,   24};
    vecs[2] = '{6'd10, 4'd13, -1, 0, 1'b0, 13'd20,  20};
    vecs[3] = '{6'd0,  4'd0,   0, 2, 1'b0, 13'd0,   22};
    vecs[4] = '{6'd63, 4'd11, -1, 0, 1'b1, 13'd126, 20};

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_text_row = '0;
    i_cell_row = '0;
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort during PIXELS of cell 0 at column 4: only columns 0..3 get written.
    w = ram_word(13'd6);
    for (int col = 0; col < 4; col++) exp_q.push_back({4'(col), exp_pix(w, 4'd5, col)});
    done_cnt = 0;
    n_writes = 0;
    @(negedge i_clk);
    i_text_row = 6'd3;
    i_cell_row = 4'd5;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (5) @(negedge i_clk);
    chk("abort_at_col", o_column, 3'd4);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_we", o_lb_we, 1'b0);
    repeat (20) @(negedge i_clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_writes", n_writes, 4);
    chk("abort_pending", exp_q.size(), 0);
    exp_q.delete();
    run_vec(vecs[0]);

    // Asynchronous reset while waiting in FETCH.
    delay_addr = 10;
    delay_n = 50;
    @(negedge i_clk);
    i_text_row = 6'd5;
    i_cell_row = 4'd2;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("pre_reset_req", o_ram_req, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    delay_addr = -1;
    delay_n = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_reset_busy", o_busy, 1'b0);

    // Abort coincident with ack: data must not be latched.
    auto_ram = 1'b0;
    done_cnt = 0;
    @(negedge i_clk);
    i_text_row = 6'd2;
    i_cell_row = 4'd1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("ack_abort_req", o_ram_req, 1'b1);
    ack_man = 1'b1;
    data_man = {8'hEE, 12'hABC, 12'hDEF};
    i_abort = 1'b1;
    @(negedge i_clk);
    ack_man = 1'b0;
    data_man = 32'hDEADBEEF;
    i_abort = 1'b0;
    chk("ack_abort_busy", o_busy, 1'b0);
    chk("ack_abort_req_low", o_ram_req, 1'b0);
    chk("ack_abort_char", o_char, 8'h00);
    chk("ack_abort_fg", o_fg_color, 12'h000);
    chk("ack_abort_bg", o_bg_color, 12'h000);
    repeat (3) @(negedge i_clk);
    chk("ack_abort_stays_idle", o_busy, 1'b0);
    chk("ack_abort_no_done", done_cnt, 0);
    auto_ram = 1'b1;

    run_vec(vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
